// File: rtl/div3_pkg.sv
// div3_pkg: shared widths and round-robin pick helper
// for the constant-divider arbiters.
package div3_pkg;

    localparam int X_W     = 64;
    localparam int Q_W     = 63;
    localparam int R_W     = 2;
    localparam int CNT_W   = 32;
    localparam int MAX_REQ = 16;
    localparam int PTR_W   = 4;

    typedef struct packed {
        logic             found;
        logic [PTR_W-1:0] idx;
    } rr_pick_t;

    // First set bit of valid at or after ptr, wrapping at n.
    function automatic rr_pick_t rr_pick(
        input logic [MAX_REQ-1:0] valid,
        input logic [PTR_W-1:0]   ptr,
        input int                 n
    );
        rr_pick_t res;
        int       j;
        res = '0;
        for (int k = 0; k < MAX_REQ; k++) begin
            j = int'(ptr) + k;
            if (j >= n) j = j - n;
            if (k < n && !res.found && valid[j[PTR_W-1:0]]) begin
                res.found = 1'b1;
                res.idx   = j[PTR_W-1:0];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/div_64_3_stand.sv
// div_64_3_stand: combinational 64-bit divide by 3,
// restoring long division one dividend bit at a time.
module div_64_3_stand
    import div3_pkg::*;
(
    input  logic [X_W-1:0] x,
    output logic [Q_W-1:0] q,
    output logic [R_W-1:0] r
);

    logic [2:0] t;
    logic [1:0] rem;

    // The top dividend bit alone is below 3, so it only seeds the remainder.
    always_comb begin
        q   = '0;
        t   = '0;
        rem = {1'b0, x[X_W-1]};
        for (int i = Q_W - 1; i >= 0; i--) begin
            t = {rem, x[i]};
            if (t >= 3'd3) begin
                q[i] = 1'b1;
                rem  = 2'(t - 3'd3);
            end else begin
                rem = t[1:0];
            end
        end
        r = rem;
    end

endmodule

// File: rtl/div3_rr_arbiter.sv
// div3_rr_arbiter: round-robin share of one divide-by-3
// datapath with a two-register pipeline and response backpressure.
module div3_rr_arbiter
    import div3_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [64*NUM_REQ-1:0]  req_x,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [Q_W-1:0]         rsp_q,
    output logic [R_W-1:0]         rsp_r,
    output logic [ID_W-1:0]        rsp_id,
    output logic [CNT_W-1:0]       done_count
);

    logic            adv;
    logic            hs;
    rr_pick_t        pick;
    logic [ID_W-1:0] win;
    logic [ID_W-1:0] rr_ptr;
    logic [ID_W-1:0] ptr_nxt;

    logic            s1_valid;
    logic [X_W-1:0]  s1_x;
    logic [ID_W-1:0] s1_id;

    logic            s2_valid;
    logic [Q_W-1:0]  s2_q;
    logic [R_W-1:0]  s2_r;
    logic [ID_W-1:0] s2_id;

    logic [Q_W-1:0]  core_q;
    logic [R_W-1:0]  core_r;

    assign adv = ~s2_valid | rsp_ready;

    // Grant the first valid requester from rr_ptr, only when the pipe moves.
    always_comb begin
        pick      = rr_pick(MAX_REQ'(req_valid), PTR_W'(rr_ptr), NUM_REQ);
        win       = ID_W'(pick.idx);
        hs        = pick.found & adv;
        req_ready = '0;
        if (hs) req_ready = NUM_REQ'(1) << win;
        ptr_nxt = (win == ID_W'(NUM_REQ - 1)) ? '0 : win + ID_W'(1);
    end

    div_64_3_stand u_core (
        .x (s1_x),
        .q (core_q),
        .r (core_r)
    );

    // Both stages shift together on adv; a stall freezes the whole pipe.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_x     <= '0;
            s1_id    <= '0;
            s2_valid <= 1'b0;
            s2_q     <= '0;
            s2_r     <= '0;
            s2_id    <= '0;
            rr_ptr   <= '0;
        end else if (adv) begin
            s1_valid <= hs;
            if (hs) begin
                s1_x   <= req_x[64*win +: 64];
                s1_id  <= win;
                rr_ptr <= ptr_nxt;
            end
            s2_valid <= s1_valid;
            s2_q     <= core_q;
            s2_r     <= core_r;
            s2_id    <= s1_id;
        end
    end

    // Debug count of response handshakes, free-running wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            done_count <= '0;
        end else if (s2_valid && rsp_ready) begin
            done_count <= done_count + CNT_W'(1);
        end
    end

    assign rsp_valid = s2_valid;
    assign rsp_q     = s2_q;
    assign rsp_r     = s2_r;
    assign rsp_id    = s2_id;

endmodule
